div_sequencer: RTL and testbench

- Issue/response controller that sequences the shared multi-cycle 64-bit divider used by the EX-stage ALU for DIV/DIVU/DIVW/DIVUW/REM/REMU/REMW/REMUW.
- Accepts one request at a time over a valid/ready handshake, holds the operands stable, and pulses the divider start.
- Waits for completion, selects and sign-extends the result, then holds it until EX consumes it.
- Handles pipeline flush, divider timeout and, optionally, the RISC-V divide-by-zero and overflow corner cases without using the divider.

---
 rtl/div_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_div_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Purpose: issue/response sequencer for the shared multi-cycle 64-bit divider (DIV/REM and W forms); optional DIV_SEQ_FASTPATH_EN fast path.
// Latency: accept at T, div_start at T+1, divider complete at C, rsp_valid at C+1 (fast path: rsp_valid at T+1).
// Backpressure: one op in flight; req_ready only in IDLE or in DONE with rsp_ready; the result is held until rsp_ready.
module div_sequencer #(
  parameter int XLEN       = 64,
  parameter int MAX_CYCLES = 80
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_w,
  input  logic            req_div,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_dividend,
  input  logic [XLEN-1:0] req_divisor,
  output logic            div_start,
  output logic            div_w,
  output logic            div_div,
  output logic            div_signed,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_complete,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  // Control bits that travel with the latched operands.
  typedef struct packed {
    logic w;
    logic div;
    logic sgn;
  } op_ctl_t;

  localparam logic        WD_EN   = (MAX_CYCLES != 0);
  localparam logic [31:0] CNT_MAX = 32'(MAX_CYCLES);

  state_t          state_q;
  state_t          state_d;
  op_ctl_t         ctl_q;
  logic [31:0]     cnt_q;
  logic            accept;
  logic            wd_expire;
  logic            fast_hit;
  logic [XLEN-1:0] fast_data;
  logic [XLEN-1:0] div_sel;
  logic [XLEN-1:0] div_result;
  logic            rsp_load;
  logic [XLEN-1:0] rsp_next;
  logic            set_timeout;

  // Handshake and watchdog expiry; the watchdog only fires when the divider has not completed this cycle.
  always_comb begin
    req_ready = !reset && !flush &&
                ((state_q == IDLE) || ((state_q == DONE) && rsp_ready));
    accept    = req_valid && req_ready;
    wd_expire = WD_EN && (cnt_q == CNT_MAX) && !div_complete;
  end

  // Pick quotient or remainder and sign-extend from bit 31 for W forms.
  always_comb begin
    div_sel    = ctl_q.div ? div_quotient : div_remainder;
    div_result = ctl_q.w ? {{(XLEN-32){div_sel[31]}}, div_sel[31:0]} : div_sel;
  end

`ifdef DIV_SEQ_FASTPATH_EN
  logic            fp_zero;
  logic            fp_ovf;
  logic [XLEN-1:0] fp_dvd_ext;

  // Divide-by-zero and signed overflow are answered without the divider.
  always_comb begin
    fp_zero    = req_w ? (req_divisor[31:0] == 32'd0) : (req_divisor == '0);
    fp_ovf     = req_signed &&
                 (req_w ? ((req_dividend[31:0] == 32'h8000_0000) && (req_divisor[31:0] == 32'hFFFF_FFFF))
                        : ((req_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (req_divisor == '1)));
    fp_dvd_ext = req_w ? {{(XLEN-32){req_dividend[31]}}, req_dividend[31:0]} : req_dividend;
    fast_hit   = fp_zero || fp_ovf;
    fast_data  = '0;
    if (fp_zero) begin
      fast_data = req_div ? '1 : fp_dvd_ext;
    end else if (fp_ovf) begin
      fast_data = req_div ? fp_dvd_ext : '0;
    end
  end
`else
  assign fast_hit  = 1'b0;
  assign fast_data = '0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the result-load and timeout-set strobes.
  always_comb begin
    state_d     = state_q;
    rsp_load    = 1'b0;
    rsp_next    = rsp_data;
    set_timeout = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (fast_hit) begin
            state_d  = DONE;
            rsp_load = 1'b1;
            rsp_next = fast_data;
          end else begin
            state_d = BUSY;
          end
        end else if ((state_q == DONE) && (flush || rsp_ready)) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (div_complete) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            state_d  = DONE;
            rsp_load = 1'b1;
            rsp_next = div_result;
          end
        end else if (wd_expire) begin
          // A hung divider cannot be drained, so a coincident flush simply drops to IDLE.
          set_timeout = 1'b1;
          if (flush) begin
            state_d = IDLE;
          end else begin
            state_d  = DONE;
            rsp_load = 1'b1;
            rsp_next = '1;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (div_complete) begin
          state_d = IDLE;
        end else if (wd_expire) begin
          set_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/control latch and the one-cycle divider start pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctl_q        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_start    <= 1'b0;
    end else begin
      div_start <= accept && !fast_hit;
      if (accept) begin
        ctl_q.w      <= req_w;
        ctl_q.div    <= req_div;
        ctl_q.sgn    <= req_signed;
        div_dividend <= req_dividend;
        div_divisor  <= req_divisor;
      end
    end
  end

  // Result register; keeps its last value while no response is pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
    end else if (rsp_load) begin
      rsp_data <= rsp_next;
    end
  end

  // Watchdog counter reads zero in the div_start cycle and advances while the divider is running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == BUSY) || (state_q == DRAIN)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (set_timeout) begin
      timeout <= 1'b1;
    end
  end

  assign rsp_valid  = (state_q == DONE);
  assign div_w      = ctl_q.w;
  assign div_div    = ctl_q.div;
  assign div_signed = ctl_q.sgn;

endmodule

// File: tb/tb_div_sequencer.sv
// Purpose: directed, table-driven checks of div_sequencer with a hand-driven divider model.
// Latency: drives inputs at the falling edge and samples outputs 1ns later.
// Backpressure: exercises rsp_ready hold, back-to-back accept, flush/drain and the watchdog.
module tb_div_sequencer;

  typedef struct {
    logic        w;
    logic        dv;
    logic        sg;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic [63:0] quo;
    logic [63:0] rem;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush, req_valid, req_w, req_div, req_signed, rsp_ready;
  logic [63:0] req_dividend, req_divisor;
  logic        div_complete;
  logic [63:0] div_quotient, div_remainder;
  logic        req_ready, div_start, div_w, div_div, div_signed, rsp_valid, timeout;
  logic [63:0] div_dividend, div_divisor, rsp_data;

  logic        w_req_valid, w_rsp_ready;
  logic        w_req_ready, w_div_start, w_div_w, w_div_div, w_div_signed, w_rsp_valid, w_timeout;
  logic [63:0] w_div_dividend, w_div_divisor, w_rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  div_sequencer #(.XLEN(64), .MAX_CYCLES(80)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_w(req_w), .req_div(req_div),
    .req_signed(req_signed), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_w(div_w), .div_div(div_div), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_complete(div_complete), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .timeout(timeout)
  );

  // Second instance with a short watchdog and a divider that never completes.
  div_sequencer #(.XLEN(64), .MAX_CYCLES(4)) dut_wd (
    .clock(clock), .reset(reset), .flush(1'b0),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_w(1'b0), .req_div(1'b1),
    .req_signed(1'b0), .req_dividend(64'h55), .req_divisor(64'h3),
    .div_start(w_div_start), .div_w(w_div_w), .div_div(w_div_div), .div_signed(w_div_signed),
    .div_dividend(w_div_dividend), .div_divisor(w_div_divisor),
    .div_complete(1'b0), .div_quotient(64'h0), .div_remainder(64'h0),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data), .timeout(w_timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_w        = v.w;
    req_div      = v.dv;
    req_signed   = v.sg;
    req_dividend = v.dividend;
    req_divisor  = v.divisor;
  endtask

  // Full operation through the divider: accept, start pulse, complete after v.lat cycles, consume.
  task automatic run_op(input vec_t v, input string tag);
    @(negedge clock);
    drive_req(v);
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    #1 chk({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    chk({tag, " div_dividend"}, div_dividend, v.dividend);
    chk({tag, " div_divisor"}, div_divisor, v.divisor);
    chk({tag, " div ctl"}, 64'({div_w, div_div, div_signed}), 64'({v.w, v.dv, v.sg}));
    for (int k = 0; k <= v.lat; k++) begin
      if (k > 0) @(negedge clock);
      div_complete  = (k == v.lat);
      div_quotient  = v.quo;
      div_remainder = v.rem;
      #1;
      chk({tag, " div_start"}, 64'(div_start), 64'(k == 0));
      chk({tag, " rsp_valid busy"}, 64'(rsp_valid), 64'd0);
    end
    @(negedge clock);
    div_complete  = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
    #1;
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, " rsp_data"}, rsp_data, v.exp);
    rsp_ready = 1'b1;
    #1 chk({tag, " req_ready done"}, 64'(req_ready), 64'd1);
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    chk({tag, " rsp_valid consumed"}, 64'(rsp_valid), 64'd0);
    chk({tag, " rsp_data kept"}, rsp_data, v.exp);
  endtask

`ifdef DIV_SEQ_FASTPATH_EN
  task automatic fast_op(input vec_t v, input string tag);
    @(negedge clock);
    drive_req(v);
    req_valid = 1'b1;
    #1 chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    chk({tag, " no div_start"}, 64'(div_start), 64'd0);
    chk({tag, " rsp_valid T+1"}, 64'(rsp_valid), 64'd1);
    chk({tag, " rsp_data"}, rsp_data, v.exp);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    #1 chk({tag, " consumed"}, 64'(rsp_valid), 64'd0);
  endtask
`endif

  vec_t vecs[7];
  vec_t v;
  vec_t b;
  int   starts;

  initial begin
    vecs[0] = '{w:1'b0, dv:1'b1, sg:1'b1, dividend:64'hFFFF_FFFF_FFFF_FFEC, divisor:64'd3,
                quo:64'hFFFF_FFFF_FFFF_FFFA, rem:64'hFFFF_FFFF_FFFF_FFFE, exp:64'hFFFF_FFFF_FFFF_FFFA, lat:3};
    vecs[1] = '{w:1'b1, dv:1'b0, sg:1'b0, dividend:64'h1_8000_0007, divisor:64'h10,
                quo:64'h1800_0000, rem:64'h7, exp:64'h7, lat:2};
    vecs[2] = '{w:1'b1, dv:1'b0, sg:1'b0, dividend:64'h1_8000_0007, divisor:64'h10,
                quo:64'h1800_0000, rem:64'h8000_0000, exp:64'hFFFF_FFFF_8000_0000, lat:1};
    vecs[3] = '{w:1'b0, dv:1'b1, sg:1'b0, dividend:64'hFFFF_FFFF_FFFF_FFFF, divisor:64'd2,
                quo:64'h7FFF_FFFF_FFFF_FFFF, rem:64'd1, exp:64'h7FFF_FFFF_FFFF_FFFF, lat:0};
    vecs[4] = '{w:1'b1, dv:1'b1, sg:1'b1, dividend:64'hABCD_0000_7FFF_FFFF, divisor:64'd1,
                quo:64'hABCD_0000_7FFF_FFFF, rem:64'd0, exp:64'h0000_0000_7FFF_FFFF, lat:4};
    vecs[5] = '{w:1'b0, dv:1'b0, sg:1'b1, dividend:64'h1234_5678_9ABC_DEF0, divisor:64'h7FFF_0000_0000_0001,
                quo:64'd0, rem:64'h1234_5678_9ABC_DEF0, exp:64'h1234_5678_9ABC_DEF0, lat:2};
    vecs[6] = '{w:1'b1, dv:1'b1, sg:1'b0, dividend:64'h3, divisor:64'h1,
                quo:64'h0000_0001_FFFF_FFFE, rem:64'd0, exp:64'hFFFF_FFFF_FFFF_FFFE, lat:1};

    reset = 1'b1; flush = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    req_w = 1'b0; req_div = 1'b0; req_signed = 1'b0; req_dividend = '0; req_divisor = '0;
    div_complete = 1'b0; div_quotient = '0; div_remainder = '0;
    w_req_valid = 1'b0; w_rsp_ready = 1'b0;

    // Reset state.
    @(negedge clock);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset div_start", 64'(div_start), 64'd0);
    chk("reset div ctl", 64'({div_w, div_div, div_signed}), 64'd0);
    chk("reset div_dividend", div_dividend, 64'd0);
    chk("reset div_divisor", div_divisor, 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_data", rsp_data, 64'd0);
    chk("reset timeout", 64'(timeout), 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Signed DIV with a 10-cycle divider and a 3-cycle hold.
    v = vecs[0];
    @(negedge clock);
    drive_req(v);
    req_valid = 1'b1;
    #1 chk("t1 req_ready", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    #1 chk("t1 div_start T+1", 64'(div_start), 64'd1);
    starts = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      div_complete  = (k == 10);
      div_quotient  = v.quo;
      div_remainder = v.rem;
      #1;
      if (div_start) starts++;
      chk("t1 rsp_valid busy", 64'(rsp_valid), 64'd0);
    end
    chk("t1 single start pulse", 64'(starts), 64'd0);
    @(negedge clock);
    div_complete = 1'b0;
    #1;
    chk("t1 rsp_valid C+1", 64'(rsp_valid), 64'd1);
    chk("t1 rsp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFA);
    for (int h = 0; h < 3; h++) begin
      @(negedge clock);
      #1;
      chk("t1 hold rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t1 hold rsp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("t1 hold req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    chk("t1 consumed", 64'(rsp_valid), 64'd0);
    chk("t1 no timeout", 64'(timeout), 64'd0);

    // Back-to-back: consume A and accept B in the same cycle.
    v = vecs[0];
    b = vecs[5];
    @(negedge clock);
    drive_req(v);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid    = 1'b0;
    div_complete = 1'b1;
    div_quotient = v.quo;
    @(negedge clock);
    div_complete = 1'b0;
    #1 chk("b2b A valid", 64'(rsp_valid), 64'd1);
    drive_req(b);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    #1 chk("b2b req_ready", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("b2b div_start", 64'(div_start), 64'd1);
    chk("b2b rsp_valid low", 64'(rsp_valid), 64'd0);
    chk("b2b operand B", div_dividend, b.dividend);
    @(negedge clock);
    div_complete  = 1'b1;
    div_remainder = b.rem;
    #1;
    chk("b2b single start", 64'(div_start), 64'd0);
    chk("b2b still low", 64'(rsp_valid), 64'd0);
    @(negedge clock);
    div_complete = 1'b0;
    #1;
    chk("b2b B valid", 64'(rsp_valid), 64'd1);
    chk("b2b B data", rsp_data, b.exp);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;

    // Flush in the third BUSY cycle, divider completes 7 cycles later.
    @(negedge clock);
    drive_req(vecs[5]);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    flush = 1'b1;
    #1 chk("flush busy req_ready", 64'(req_ready), 64'd0);
    for (int k = 3; k <= 9; k++) begin
      @(negedge clock);
      flush         = 1'b0;
      div_complete  = (k == 9);
      div_remainder = 64'hDEAD;
      #1;
      chk("drain req_ready", 64'(req_ready), 64'd0);
      chk("drain rsp_valid", 64'(rsp_valid), 64'd0);
    end
    @(negedge clock);
    div_complete = 1'b0;
    #1;
    chk("drain done rsp_valid", 64'(rsp_valid), 64'd0);
    chk("drain done req_ready", 64'(req_ready), 64'd1);

    // Flush together with complete in BUSY: result dropped, straight to IDLE.
    @(negedge clock);
    drive_req(vecs[0]);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid    = 1'b0;
    flush        = 1'b1;
    div_complete = 1'b1;
    @(negedge clock);
    flush        = 1'b0;
    div_complete = 1'b0;
    #1;
    chk("flush+cmpl rsp_valid", 64'(rsp_valid), 64'd0);
    chk("flush+cmpl idle", 64'(req_ready), 64'd1);

    // Flush in DONE blocks any accept and clears rsp_valid.
    @(negedge clock);
    drive_req(vecs[0]);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid    = 1'b0;
    div_complete = 1'b1;
    @(negedge clock);
    div_complete = 1'b0;
    #1 chk("flush done valid", 64'(rsp_valid), 64'd1);
    flush     = 1'b1;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    #1 chk("flush done req_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    flush     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("flush done cleared", 64'(rsp_valid), 64'd0);
    chk("flush done no start", 64'(div_start), 64'd0);

    // Flush in IDLE with a request pending: nothing accepted.
    @(negedge clock);
    flush     = 1'b1;
    req_valid = 1'b1;
    #1 chk("flush idle req_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flush idle no start", 64'(div_start), 64'd0);
    chk("flush idle ready", 64'(req_ready), 64'd1);

    // Divide by zero: fast path answers at T+1, otherwise it goes through the divider.
`ifdef DIV_SEQ_FASTPATH_EN
    v = '{w:1'b1, dv:1'b1, sg:1'b1, dividend:64'h8000_0000, divisor:64'hFFFF_FFFF,
          quo:64'd0, rem:64'd0, exp:64'hFFFF_FFFF_8000_0000, lat:0};
    fast_op(v, "fp divw ovf");
    v = '{w:1'b0, dv:1'b0, sg:1'b0, dividend:64'h1234, divisor:64'd0,
          quo:64'd0, rem:64'd0, exp:64'h1234, lat:0};
    fast_op(v, "fp remu zero");
`else
    v = '{w:1'b0, dv:1'b0, sg:1'b0, dividend:64'h1234, divisor:64'd0,
          quo:64'hFFFF_FFFF_FFFF_FFFF, rem:64'h1234, exp:64'h1234, lat:1};
    run_op(v, "remu zero via divider");
`endif

    // Watchdog on the MAX_CYCLES=4 instance.
    @(negedge clock);
    w_req_valid = 1'b1;
    #1 chk("wd req_ready", 64'(w_req_ready), 64'd1);
    @(negedge clock);
    w_req_valid = 1'b0;
    #1;
    chk("wd div_start", 64'(w_div_start), 64'd1);
    chk("wd operands", {w_div_dividend[31:0], w_div_divisor[31:0]}, {32'h55, 32'h3});
    chk("wd ctl", 64'({w_div_w, w_div_div, w_div_signed}), 64'b010);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      #1;
      chk("wd rsp_valid early", 64'(w_rsp_valid), 64'd0);
      chk("wd timeout early", 64'(w_timeout), 64'd0);
    end
    @(negedge clock);
    #1;
    chk("wd rsp_valid", 64'(w_rsp_valid), 64'd1);
    chk("wd rsp_data", w_rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wd timeout", 64'(w_timeout), 64'd1);
    w_rsp_ready = 1'b1;
    @(negedge clock);
    w_rsp_ready = 1'b0;
    #1 chk("wd consumed", 64'(w_rsp_valid), 64'd0);
    repeat (5) @(negedge clock);
    #1;
    chk("wd timeout sticky", 64'(w_timeout), 64'd1);
    chk("wd idle", 64'(w_req_ready), 64'd1);
    reset = 1'b1;
    #1;
    chk("wd timeout reset", 64'(w_timeout), 64'd0);
    chk("reset rsp_data again", rsp_data, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
